pipelined_cla_addsub: RTL

Parametrised, pipelined carry-lookahead adder/subtractor for the processor datapath ALU. The operand width is split into CHUNK-bit lookahead groups, with one group resolved per pipeline stage. The carry between groups is registered, so a new operation can enter every cycle. A global stall freezes the whole pipeline without losing or duplicating in-flight operations.

---
 rtl/pipelined_cla_addsub.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The operand width is split into CHUNK-bit lookahead groups; stage k resolves group k.
// Each stage registers the partial result, its group carry-out and the upper operand
// bits that later stages still need. A global stall holds every register.
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    input  logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    // Lookahead within one group: returns {carry_out, sum}.
    // Each bit carry is formed from the group prefix generate/propagate and the carry-in.
    function automatic logic [CHUNK:0] cla_group(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             cin
    );
        logic [CHUNK-1:0] p;
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] c;
        logic             gg;
        logic             pp;
        p  = a ^ b;
        g  = a & b;
        c  = '0;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < int'(CHUNK); i++) begin
            c[i] = gg | (pp & cin);
            gg   = g[i] | (p[i] & gg);
            pp   = pp & p[i];
        end
        return {gg | (pp & cin), p ^ c};
    endfunction

    // Subtraction is A + ~B + 1: invert B here, carry-in of group 0 is ctrl_sub.
    logic [WIDTH-1:0] operand_b_eff;
    assign operand_b_eff = data_operandB ^ {WIDTH{ctrl_sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned SrcW = WIDTH - k * CHUNK;  // operand bits not yet resolved
        localparam int unsigned UpW  = SrcW - CHUNK;       // bits left after this group
        localparam int unsigned ResW = (k + 1) * CHUNK;    // result bits known after this stage

        logic [SrcW-1:0] src_a;
        logic [SrcW-1:0] src_b;
        logic            cin;
        logic            vin;
        logic [CHUNK:0]  grp;
        logic [ResW-1:0] res_d;
        logic [ResW-1:0] res_q;
        logic            c_q;
        logic            v_q;

        if (k == 0) begin : g_src
            assign src_a = data_operandA;
            assign src_b = operand_b_eff;
            assign cin   = ctrl_sub;
            assign vin   = in_valid && !stall;
            assign res_d = grp[CHUNK-1:0];
        end else begin : g_src
            assign src_a = g_stage[k-1].g_up.a_q;
            assign src_b = g_stage[k-1].g_up.b_q;
            assign cin   = g_stage[k-1].c_q;
            assign vin   = g_stage[k-1].v_q;
            assign res_d = {grp[CHUNK-1:0], g_stage[k-1].res_q};
        end

        assign grp = cla_group(src_a[CHUNK-1:0], src_b[CHUNK-1:0], cin);

        // Valid bit: cleared by reset, otherwise advances unless stalled.
        always_ff @(posedge clock) begin
            if (reset) begin
                v_q <= 1'b0;
            end else if (!stall) begin
                v_q <= vin;
            end
        end

        // Result and group carry: only the output stage is reset so outputs read zero.
        always_ff @(posedge clock) begin
            if (reset && (k == STAGES - 1)) begin
                res_q <= '0;
                c_q   <= 1'b0;
            end else if (!stall) begin
                res_q <= res_d;
                c_q   <= grp[CHUNK];
            end
        end

        if (k < STAGES - 1) begin : g_up
            logic [UpW-1:0] a_q;
            logic [UpW-1:0] b_q;

            // Skew the unresolved upper operand bits forward to the next stage.
            always_ff @(posedge clock) begin
                if (!stall) begin
                    a_q <= src_a[SrcW-1:CHUNK];
                    b_q <= src_b[SrcW-1:CHUNK];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ov_q;

            // Signed overflow: operand signs agree but the result sign differs.
            always_ff @(posedge clock) begin
                if (reset) begin
                    ov_q <= 1'b0;
                end else if (!stall) begin
                    ov_q <= (src_a[CHUNK-1] == src_b[CHUNK-1]) &&
                            (grp[CHUNK-1] != src_a[CHUNK-1]);
                end
            end
        end
    end

    assign out_valid   = g_stage[STAGES-1].v_q;
    assign data_result = g_stage[STAGES-1].res_q;
    assign carry_out   = g_stage[STAGES-1].c_q;
    assign overflow    = g_stage[STAGES-1].g_last.ov_q;

endmodule
